// File: rtl/serial_twos_deserializer_if.sv
// Serial two's-complement receive bundle: serial bits in, recovered word out.
interface serial_twos_deserializer_if #(
  parameter int WIDTH = 16
);
  logic             inp;
  logic             bit_en;
  logic             start;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             busy;
  logic             ovf;

  modport master (
    output inp, bit_en, start,
    input  data, valid, busy, ovf
  );

  modport slave (
    input  inp, bit_en, start,
    output data, valid, busy, ovf
  );
endinterface

// File: rtl/serial_twos_deserializer.sv
// Bit-serial two's-complement un-negator and deserializer, LSB first.
// Optional macro OVF_FLAG_EN builds the most-negative-value flag.
module serial_twos_deserializer #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic reset,
  serial_twos_deserializer_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    S0,
    S1
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [WIDTH-1:0] data_q, data_nx;
  logic             valid_q, valid_nx;
  logic             ovf_q, ovf_nx;
  logic             sbit, last, mid, rec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sr      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      sr      <= sr_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      ovf_q   <= ovf_nx;
    end
  end

  always_comb begin
    sbit = bus.bit_en & bus.start;
    last = bus.bit_en & ~bus.start & (state != IDLE)
         & (cnt == CW'(WIDTH - 1));
    mid  = bus.bit_en & ~bus.start & (state != IDLE)
         & (cnt != CW'(WIDTH - 1));
    // After the first 1 every later bit is inverted back
    rec  = (state == S1 && !sbit) ? ~bus.inp : bus.inp;

    state_nx = state;
    cnt_nx   = cnt;
    sr_nx    = sr;
    data_nx  = data_q;
    valid_nx = 1'b0;
    ovf_nx   = ovf_q;

    unique case (1'b1)
      sbit: begin
        state_nx = bus.inp ? S1 : S0;
        cnt_nx   = CW'(1);
        sr_nx    = {rec, {(WIDTH-1){1'b0}}};
      end
      last: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        sr_nx    = '0;
        data_nx  = {rec, sr[WIDTH-1:1]};
        valid_nx = 1'b1;
`ifdef OVF_FLAG_EN
        ovf_nx   = (state == S0) & bus.inp;
`else
        ovf_nx   = 1'b0;
`endif
      end
      mid: begin
        state_nx = bus.inp ? S1 : state;
        cnt_nx   = cnt + CW'(1);
        sr_nx    = {rec, sr[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_serial_twos_deserializer.sv
// Scoreboard bench: expected words from arithmetic negation of each frame.
module tb_serial_twos_deserializer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic prev_valid = 1'b0;
  logic [W:0] exp_q[$];

  serial_twos_deserializer_if #(.WIDTH(W)) bus ();

  serial_twos_deserializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] frame);
    logic [W-1:0] orig;
    logic         o;
    orig = W'(-frame);
`ifdef OVF_FLAG_EN
    o = (frame == {1'b1, {(W-1){1'b0}}});
`else
    o = 1'b0;
`endif
    return {o, orig};
  endfunction

  // Drive bits lo..hi of frame w; gap idle cycles after each bit.
  task automatic send_bits(input logic [W-1:0] w, input int lo,
                           input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      bus.inp    = w[i];
      bus.bit_en = 1'b1;
      bus.start  = (i == 0);
      if (i == W - 1) exp_q.push_back(model(w));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bus.bit_en = 1'b0;
        bus.start  = 1'b0;
        bus.inp    = 1'($urandom);
      end
    end
  endtask

  task automatic idle_check_busy(input string name);
    @(negedge clk);
    bus.bit_en = 1'b0;
    bus.start  = 1'b0;
    chk(name, 32'(bus.busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_valid && bus.valid) begin
        tests++;
        fails++;
        $display("FAIL valid_twice: valid high two cycles in a row");
      end
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: data %0h", bus.data);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk("data", 32'(bus.data), 32'(e[W-1:0]));
          chk("ovf", 32'(bus.ovf), 32'(e[W]));
        end
      end
    end
    prev_valid = bus.valid;
  end

  initial begin
    logic [W-1:0] w;
    reset      = 1'b1;
    bus.inp    = 1'b0;
    bus.bit_en = 1'b0;
    bus.start  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    send_bits(16'hFFFB, 0, 15, 0);
    idle_check_busy("busy_after_fffb");

    send_bits(16'h0000, 0, 15, 0);
    send_bits(16'h8000, 0, 15, 0);
    idle_check_busy("busy_after_8000");

    send_bits(16'h9668, 0, 15, 3);
    idle_check_busy("busy_after_gap");

    send_bits(16'h1234, 0, 6, 0);
    send_bits(16'hFFFF, 0, 15, 0);
    idle_check_busy("busy_after_abort");

    send_bits(16'hABCD, 0, 9, 0);
    @(negedge clk);
    bus.bit_en = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_data", 32'(bus.data), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    send_bits(16'h001F, 1, 5, 0);
    idle_check_busy("busy_no_start");
    chk("no_start_data", 32'(bus.data), 32'd0);
    send_bits(16'hFFFE, 0, 15, 0);
    idle_check_busy("busy_after_fffe");

    send_bits(16'h5A5A, 0, 14, 0);
    send_bits(16'h0010, 0, 0, 0);
    @(negedge clk);
    bus.bit_en = 1'b0;
    bus.start  = 1'b0;
    chk("restart_busy", 32'(bus.busy), 32'd1);
    chk("restart_valid", 32'(bus.valid), 32'd0);
    send_bits(16'h0010, 1, 15, 0);
    idle_check_busy("busy_after_restart");

    for (int k = 0; k < 24; k++) begin
      int sel;
      int gap;
      sel = $urandom_range(0, 9);
      gap = $urandom_range(0, 2);
      w   = W'($urandom);
      if (sel == 0) w = 16'h8000;
      if (sel == 1) w = 16'h0000;
      if (sel == 2) send_bits(W'($urandom), 0, $urandom_range(1, 14), gap);
      send_bits(w, 0, 15, gap);
    end

    @(negedge clk);
    bus.bit_en = 1'b0;
    bus.start  = 1'b0;
    repeat (6) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
